mc_cnt_gen: RTL and testbench
=============================

Name: mc_cnt_gen

Overview:
- Parametrised up/down counter, successor to the fixed 5-bit mc counter.
- Counts within a programmable [MIN, MAX] window.
- Boundary policy is selected at run time by mode: wrap, saturate, bounce (ping-pong) or hold.
- Provides synchronous clear/load, an enable, a direction status and a registered boundary-event pulse; used as a general sequencer/address/timer source in the examples.

Parameters:
- WIDTH, 5, counter width in bits (>=2).
- MIN, 0, lower bound of count window.
- MAX, 31, upper bound of count window; MIN < MAX <= 2^WIDTH-1, checked at elaboration.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- clr  in  1  synchronous clear to MIN.
- load  in  1  synchronous load of load_val.
- load_val  in  WIDTH  value for load.
- en  in  1  step enable.
- dir  in  1  step direction in wrap/saturate modes: 0 = up, 1 = down.
- mode  in  2  0 = wrap, 1 = saturate, 2 = bounce, 3 = hold.
- io_out  out  WIDTH  current count (registered).
- dir_out  out  1  direction used for the current step (registered bounce state in mode 2, else dir).
- evt  out  1  registered one-cycle boundary event pulse.

Behaviour:
- Reset (reset=0, async): io_out=MIN, bounce direction register=0 (up), evt=0. Reset release is clean mid-operation; the first step occurs on the first rising edge with reset=1.
- Per-edge priority: clr > load > en. With none active, io_out holds and evt=0.
- clr: io_out<=MIN, bounce dir<=up, evt<=0.
- load:
  - io_out <= load_val clamped to [MIN, MAX]: below MIN gives MIN, above MAX gives MAX.
  - Bounce dir unchanged; evt<=0.
- en, effective direction d: mode 2 uses the bounce register; other modes use dir.
- Boundary condition: (d=up and io_out==MAX) or (d=down and io_out==MIN).
- Mode 0, wrap:
  - Not at boundary: step ±1.
  - At boundary: up gives MIN, down gives MAX.
- Mode 1, saturate: not at boundary, step ±1; at boundary, hold.
- Mode 2, bounce:
  - Not at boundary: step in d.
  - At boundary: reverse the bounce register and step one in the new direction. At MAX the next value is MAX-1; at MIN the next is MIN+1.
  - MAX-MIN=1 therefore alternates MIN, MAX every cycle.
- Mode 3, hold: io_out unchanged, evt=0.
- evt: registered; high for the one cycle following an enabled step taken at the boundary in modes 0–2. evt is 0 in all other cases. Back-to-back boundary steps (e.g. saturate at MAX with en held) give evt high every such cycle.
- Out-of-window state (only reachable via a mode/window-inconsistent sequence, never via load): treated as the nearest bound on the next enabled step.
- Arithmetic is WIDTH bits, modulo-free: the next value never leaves [MIN, MAX]; no carry-out port.
- Mode or dir may change on any cycle; takes effect on that edge.
- Bounce register updates only in mode 2 steps, clr and reset; it persists across other modes.
- dir_out is combinational from mode/dir/bounce register.
- Latency: every control input affects io_out at the next rising edge.

Test Plan:
- Reset then mode=2, en=1, WIDTH=5, MIN=0, MAX=31 -> io_out 0,1,…,31,30,…,0,1; evt high the cycle after leaving 31 and after leaving 0; dir_out flips at the boundaries.
- mode=0, dir=1 from reset -> io_out 0→31→30; evt pulse once after 0→31. With dir=0 from 31 -> 0, evt pulse.
- mode=1, dir=0, en=1 starting at 29 -> 30,31,31,31; evt high on each cycle after a step taken at 31. Then dir=1 -> 30, evt=0.
- MIN=3, MAX=10, load=1 with load_val=1 -> 3; load_val=20 -> 10; clr and load both high -> 3.
- Drop reset mid-count at value 17 asynchronously (between edges) -> io_out=MIN, evt=0 immediately. Count resumes from MIN, bounce dir up.
- mode=3 with en=1 for 4 cycles -> io_out constant, evt=0. Switching to mode 2 resumes in the previously stored bounce direction.

Source files
------------

// File: rtl/mc_cnt_gen.sv
// Up/down counter confined to a [MIN, MAX] window, with a run-time boundary
// policy (wrap, saturate, bounce or hold) and a registered boundary-event pulse.
module mc_cnt_gen #(
    parameter int WIDTH = 5,
    parameter int MIN   = 0,
    parameter int MAX   = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] io_out,
    output logic             dir_out,
    output logic             evt
);

    typedef enum logic [1:0] {
        M_WRAP = 2'd0,
        M_SAT  = 2'd1,
        M_BNC  = 2'd2,
        M_HOLD = 2'd3
    } mode_e;

    localparam logic [WIDTH-1:0] MIN_V = MIN[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MAX_V = MAX[WIDTH-1:0];

    if (WIDTH < 2 || MIN < 0 || MIN >= MAX ||
        64'(MAX) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_window
        $error("mc_cnt_gen: need WIDTH>=2 and 0 <= MIN < MAX <= 2^WIDTH-1");
    end

    logic [WIDTH-1:0] io_q, io_d;
    logic             bdir_q, bdir_d;
    logic             evt_q, evt_d;

    // Window tests are generated only where a bound can actually be crossed,
    // so a full-range window does not produce constant comparisons.
    logic below_q, above_q, ld_below, ld_above;

    if (MIN > 0) begin : g_lo
        assign below_q  = (io_q < MIN_V);
        assign ld_below = (load_val < MIN_V);
    end else begin : g_lo_none
        assign below_q  = 1'b0;
        assign ld_below = 1'b0;
    end

    if (64'(MAX) < ((64'd1 << WIDTH) - 64'd1)) begin : g_hi
        assign above_q  = (io_q > MAX_V);
        assign ld_above = (load_val > MAX_V);
    end else begin : g_hi_none
        assign above_q  = 1'b0;
        assign ld_above = 1'b0;
    end

    mode_e            mode_e_w;
    logic             d_dn;
    logic [WIDTH-1:0] cur;
    logic             at_bnd;
    logic [WIDTH-1:0] cur_up, cur_dn;

    always_comb begin
        mode_e_w = mode_e'(mode);
        d_dn     = (mode_e_w == M_BNC) ? bdir_q : dir;

        // Out-of-window state steps as if it sat on the nearest bound.
        cur = io_q;
        if (below_q)      cur = MIN_V;
        else if (above_q) cur = MAX_V;

        at_bnd = d_dn ? (cur == MIN_V) : (cur == MAX_V);
        cur_up = cur + 1'b1;
        cur_dn = cur - 1'b1;
    end

    always_comb begin
        io_d   = io_q;
        bdir_d = bdir_q;
        evt_d  = 1'b0;
        if (clr) begin
            io_d   = MIN_V;
            bdir_d = 1'b0;
        end else if (load) begin
            if (ld_below)      io_d = MIN_V;
            else if (ld_above) io_d = MAX_V;
            else               io_d = load_val;
        end else if (en) begin
            case (mode_e_w)
                M_WRAP: begin
                    evt_d = at_bnd;
                    if (at_bnd) io_d = d_dn ? MAX_V : MIN_V;
                    else        io_d = d_dn ? cur_dn : cur_up;
                end
                M_SAT: begin
                    evt_d = at_bnd;
                    if (at_bnd) io_d = cur;
                    else        io_d = d_dn ? cur_dn : cur_up;
                end
                M_BNC: begin
                    evt_d = at_bnd;
                    if (at_bnd) begin
                        // Turn around and take the step in the new direction.
                        bdir_d = ~bdir_q;
                        io_d   = bdir_q ? cur_up : cur_dn;
                    end else begin
                        io_d = d_dn ? cur_dn : cur_up;
                    end
                end
                default: begin
                    io_d = io_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            io_q   <= MIN_V;
            bdir_q <= 1'b0;
            evt_q  <= 1'b0;
        end else begin
            io_q   <= io_d;
            bdir_q <= bdir_d;
            evt_q  <= evt_d;
        end
    end

    assign io_out  = io_q;
    assign evt     = evt_q;
    assign dir_out = (mode == 2'd2) ? bdir_q : dir;

endmodule

// File: tb/tb_mc_cnt_gen.sv
// Bench for mc_cnt_gen: a full-range instance and a [3,10] instance share the
// same stimulus; a behavioural model feeds a scoreboard, and tables add hand values.
module tb_mc_cnt_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clr = 1'b0, load = 1'b0, en = 1'b0, dir = 1'b0;
    logic [4:0] load_val = 5'd0;
    logic [1:0] mode = 2'd0;
    logic [4:0] io0, io1;
    logic       do0, do1, ev0, ev1;

    always #5 clk = ~clk;

    mc_cnt_gen u0 (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .dir(dir), .mode(mode), .io_out(io0), .dir_out(do0), .evt(ev0)
    );

    mc_cnt_gen #(.WIDTH(5), .MIN(3), .MAX(10)) u1 (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .dir(dir), .mode(mode), .io_out(io1), .dir_out(do1), .evt(ev1)
    );

    typedef struct {
        int cnt;
        bit bd;
        bit ev;
    } mst_t;

    typedef struct {
        int io0; bit ev0; bit do0;
        int io1; bit ev1; bit do1;
    } exp_t;

    typedef struct {
        bit c; bit l; int lv; bit e; bit dr; int md;
        int io0; bit ev0; int io1; bit ev1;
    } vec_t;

    int    total = 0;
    int    bad   = 0;
    mst_t  m0 = '{0, 1'b0, 1'b0};
    mst_t  m1 = '{3, 1'b0, 1'b0};
    exp_t  sbq[$];
    vec_t  tbl[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference behaviour in plain integer arithmetic.
    function automatic mst_t mnext(mst_t s, int lo, int hi, bit c, bit l, int lv,
                                   bit e, bit dr, int md);
        mst_t n;
        bit   down;
        int   c0;
        n = s;
        n.ev = 1'b0;
        down = (md == 2) ? s.bd : dr;
        c0 = (s.cnt < lo) ? lo : ((s.cnt > hi) ? hi : s.cnt);
        if (c) begin
            n.cnt = lo;
            n.bd  = 1'b0;
        end else if (l) begin
            n.cnt = (lv < lo) ? lo : ((lv > hi) ? hi : lv);
        end else if (e && md != 3) begin
            if ((!down && c0 == hi) || (down && c0 == lo)) begin
                n.ev = 1'b1;
                if (md == 0)      n.cnt = down ? hi : lo;
                else if (md == 1) n.cnt = c0;
                else begin
                    n.bd  = !s.bd;
                    n.cnt = down ? lo + 1 : hi - 1;
                end
            end else begin
                n.cnt = down ? c0 - 1 : c0 + 1;
            end
        end
        return n;
    endfunction

    task automatic cyc(input bit c, input bit l, input int lv, input bit e,
                       input bit dr, input int md);
        exp_t x;
        clr = c; load = l; load_val = 5'(lv); en = e; dir = dr; mode = 2'(md);
        m0 = mnext(m0, 0, 31, c, l, lv, e, dr, md);
        m1 = mnext(m1, 3, 10, c, l, lv, e, dr, md);
        x.io0 = m0.cnt; x.ev0 = m0.ev; x.do0 = (md == 2) ? m0.bd : dr;
        x.io1 = m1.cnt; x.ev1 = m1.ev; x.do1 = (md == 2) ? m1.bd : dr;
        sbq.push_back(x);
        @(posedge clk);
        #1;
        x = sbq.pop_front();
        check("u0.io_out",  32'(io0), 32'(x.io0));
        check("u0.evt",     32'(ev0), 32'(x.ev0));
        check("u0.dir_out", 32'(do0), 32'(x.do0));
        check("u1.io_out",  32'(io1), 32'(x.io1));
        check("u1.evt",     32'(ev1), 32'(x.ev1));
        check("u1.dir_out", 32'(do1), 32'(x.do1));
    endtask

    initial begin
        // c  l  lv e  dr md   io0 ev0 io1 ev1
        tbl.push_back('{1, 0, 0,  0, 0, 0,  0,  0, 3,  0});
        tbl.push_back('{0, 0, 0,  1, 1, 0,  31, 1, 10, 1});
        tbl.push_back('{0, 0, 0,  1, 1, 0,  30, 0, 9,  0});
        tbl.push_back('{0, 0, 0,  1, 0, 0,  31, 0, 10, 0});
        tbl.push_back('{0, 0, 0,  1, 0, 0,  0,  1, 3,  1});
        tbl.push_back('{0, 1, 29, 0, 0, 1,  29, 0, 10, 0});
        tbl.push_back('{0, 0, 0,  1, 0, 1,  30, 0, 10, 1});
        tbl.push_back('{0, 0, 0,  1, 0, 1,  31, 0, 10, 1});
        tbl.push_back('{0, 0, 0,  1, 0, 1,  31, 1, 10, 1});
        tbl.push_back('{0, 0, 0,  1, 0, 1,  31, 1, 10, 1});
        tbl.push_back('{0, 0, 0,  1, 1, 1,  30, 0, 9,  0});
        tbl.push_back('{0, 1, 1,  0, 0, 0,  1,  0, 3,  0});
        tbl.push_back('{0, 1, 20, 0, 0, 0,  20, 0, 10, 0});
        tbl.push_back('{1, 1, 20, 0, 0, 0,  0,  0, 3,  0});
        tbl.push_back('{0, 1, 3,  1, 0, 0,  3,  0, 3,  0});
        tbl.push_back('{0, 0, 0,  0, 0, 0,  3,  0, 3,  0});
        tbl.push_back('{0, 0, 0,  1, 0, 2,  4,  0, 4,  0});
        for (int k = 0; k < 4; k++) tbl.push_back('{0, 0, 0, 1, 0, 3, 4, 0, 4, 0});
        tbl.push_back('{0, 1, 30, 1, 0, 2,  30, 0, 10, 0});
        tbl.push_back('{0, 0, 0,  1, 0, 2,  31, 0, 9,  1});
        tbl.push_back('{0, 0, 0,  1, 0, 2,  30, 1, 8,  0});
        for (int k = 0; k < 4; k++) tbl.push_back('{0, 0, 0, 1, 1, 3, 30, 0, 8, 0});
        tbl.push_back('{0, 0, 0,  1, 1, 2,  29, 0, 7,  0});

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst u0.io_out", 32'(io0), 32'd0);
        check("rst u1.io_out", 32'(io1), 32'd3);
        check("rst u0.evt",    32'(ev0), 32'd0);
        check("rst u1.evt",    32'(ev1), 32'd0);
        check("rst u0.dir_out", 32'(do0), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Bounce sweep over the whole window
        for (int i = 1; i <= 66; i++) begin
            cyc(0, 0, 0, 1, 0, 2);
            if (i == 31) check("bnc top", 32'(io0), 32'd31);
            if (i == 32) begin
                check("bnc turn io", 32'(io0), 32'd30);
                check("bnc turn evt", 32'(ev0), 32'd1);
                check("bnc turn dir", 32'(do0), 32'd1);
            end
            if (i == 63) begin
                check("bnc bottom io", 32'(io0), 32'd1);
                check("bnc bottom evt", 32'(ev0), 32'd1);
                check("bnc bottom dir", 32'(do0), 32'd0);
            end
        end

        // Table: wrap, saturate, load clamping, priorities, hold and bounce resume
        foreach (tbl[k]) begin
            cyc(tbl[k].c, tbl[k].l, tbl[k].lv, tbl[k].e, tbl[k].dr, tbl[k].md);
            check($sformatf("tbl%0d u0.io", k),  32'(io0), 32'(tbl[k].io0));
            check($sformatf("tbl%0d u0.evt", k), 32'(ev0), 32'(tbl[k].ev0));
            check($sformatf("tbl%0d u1.io", k),  32'(io1), 32'(tbl[k].io1));
            check($sformatf("tbl%0d u1.evt", k), 32'(ev1), 32'(tbl[k].ev1));
        end

        // Asynchronous reset in the middle of a count
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++) cyc(0, 0, 0, 1, 0, 0);
        check("pre-rst io", 32'(io0), 32'd17);
        #2 reset = 1'b0;
        #1;
        check("async rst u0.io", 32'(io0), 32'd0);
        check("async rst u1.io", 32'(io1), 32'd3);
        check("async rst u0.evt", 32'(ev0), 32'd0);
        @(posedge clk);
        #1;
        check("held rst u0.io", 32'(io0), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        m0 = '{0, 1'b0, 1'b0};
        m1 = '{3, 1'b0, 1'b0};
        cyc(0, 0, 0, 1, 0, 2);
        check("resume io", 32'(io0), 32'd1);
        check("resume dir", 32'(do0), 32'd0);
        cyc(0, 0, 0, 1, 0, 2);
        cyc(0, 0, 0, 1, 0, 2);
        check("resume io3", 32'(io0), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
